// File: rtl/dii_packet_arbiter_pkg.sv
// Shared types for the debug-ring packet arbiter: the flit format and the
// arbiter FSM encoding.
package dii_packet_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dii_packet_arbiter_if.sv
// Source-side and ring-side flit buses of the arbiter. A flit moves on a
// channel in the cycle where its valid and the matching ready are both high.
interface dii_packet_arbiter_if #(
  parameter int PORTS = 2
);
  import dii_packet_arbiter_pkg::*;

  dii_flit [PORTS-1:0] in_flit;
  logic    [PORTS-1:0] in_ready;
  dii_flit             out_flit;
  logic                out_ready;

  modport master (
    output in_flit,
    output out_ready,
    input  in_ready,
    input  out_flit
  );

  modport slave (
    input  in_flit,
    input  out_ready,
    output in_ready,
    output out_flit
  );
endinterface

// File: rtl/dii_skid_buffer.sv
// Two-entry register slice for dii_flit. in_ready depends only on the fill
// level, so no combinational path runs from out_ready back upstream.
module dii_skid_buffer
  import dii_packet_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_flit,
  output logic    in_ready,
  output dii_flit out_flit,
  input  logic    out_ready
);

  dii_flit    mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready = (count != 2'd2);
  assign push     = in_flit.valid && in_ready;
  assign pop      = out_flit.valid && out_ready;

  always_comb begin
    out_flit       = mem[rd_ptr];
    out_flit.valid = (count != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one debug ring injection port
// between PORTS sources, with a two-entry skid buffer on the ring side.
module dii_packet_arbiter
  import dii_packet_arbiter_pkg::*;
#(
  parameter int PORTS       = 2,
  parameter int MAX_PKT_LEN = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  dii_packet_arbiter_if.slave                      bus,
  output logic                                     overflow_err,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] active_port,
  output arb_state_e                               dbg_state
);

  localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CNT_W  = 16;

  arb_state_e          state, state_nxt;
  logic [PORT_W-1:0]   grant, grant_nxt;
  logic [PORT_W-1:0]   rr, rr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                ovf_nxt;
  logic [PORTS-1:0]    req;
  logic [PORT_W-1:0]   pick;
  logic                found;
  logic                xfer;
  logic                force_last;
  logic                skid_ready;
  dii_flit             skid_in;

  // First requester at or above ptr, wrapping; scanning downward lets the
  // nearest candidate overwrite farther ones.
  function automatic logic [PORT_W-1:0] rr_search(input logic [PORTS-1:0] r,
                                                  input logic [PORT_W-1:0] ptr,
                                                  output logic hit);
    int idx;
    rr_search = '0;
    hit       = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (r[idx]) begin
        rr_search = PORT_W'(idx);
        hit       = 1'b1;
      end
    end
  endfunction

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    next_port = (p == PORT_W'(PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < PORTS; i++) req[i] = bus.in_flit[i].valid;
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_nxt       = rr;
    cnt_nxt      = cnt;
    ovf_nxt      = 1'b0;
    xfer         = 1'b0;
    force_last   = 1'b0;
    skid_in      = '0;
    bus.in_ready = '0;
    pick         = rr_search(req, rr, found);
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_BUSY;
          grant_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        bus.in_ready[grant] = skid_ready;
        skid_in             = bus.in_flit[grant];
        xfer                = skid_in.valid && skid_ready;
        // A packet that reaches the length limit without last is cut here;
        // the source's remaining flits arbitrate again as a new packet.
        if ((MAX_PKT_LEN != 0) && (cnt == CNT_W'(MAX_PKT_LEN - 1)) && !skid_in.last) begin
          force_last = 1'b1;
        end
        skid_in.last = skid_in.last | force_last;
        if (xfer) begin
          if (skid_in.last) begin
            state_nxt = ST_IDLE;
            rr_nxt    = next_port(grant);
            cnt_nxt   = '0;
            ovf_nxt   = force_last;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant        <= '0;
      rr           <= '0;
      cnt          <= '0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      rr           <= rr_nxt;
      cnt          <= cnt_nxt;
      overflow_err <= ovf_nxt;
    end
  end

  assign active_port = grant;
  assign dbg_state   = state;

  dii_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (skid_in),
    .in_ready  (skid_ready),
    .out_flit  (bus.out_flit),
    .out_ready (bus.out_ready)
  );

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Randomized scoreboard bench for dii_packet_arbiter: a packet-level
// round-robin model predicts the ring-side flit stream.
module tb_dii_packet_arbiter;
  import dii_packet_arbiter_pkg::*;

  localparam int PORTS = 3;
  localparam int MAXL  = 4;
  localparam int W     = 20; // {ovf, port[1:0], last, data[15:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       overflow_err;
  logic [1:0] active_port;
  arb_state_e dbg_state;

  dii_packet_arbiter_if #(.PORTS(PORTS)) bus ();

  dii_packet_arbiter #(.PORTS(PORTS), .MAX_PKT_LEN(MAXL)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .overflow_err (overflow_err),
    .active_port  (active_port),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  logic [16:0]   drv_q [PORTS][$];
  logic [16:0]   m_q   [PORTS][$];
  logic [W-1:0]  exp_q [$];
  int  mid_cnt [PORTS];
  int  m_rr = 0, seq = 0;
  int  checks = 0, errors = 0;
  int  in_fire_cnt = 0, out_fire_cnt = 0, ovf_seen = 0, ovf_exp = 0, exp_pushed = 0;
  bit  strict = 0, gap_en = 0, rdy_rand = 0, rdy_force = 1;
  bit  have_prev = 0, pop_prev_last = 0;
  int  pop_prev_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  task automatic load_pkt(input int port, input int len, input bit fixed, input logic [15:0] fdata);
    logic [15:0] d;
    for (int j = 0; j < len; j++) begin
      d = fixed ? fdata : {2'(port), 14'(seq)};
      seq++;
      drv_q[port].push_back({(j == len - 1), d});
      m_q[port].push_back({(j == len - 1), d});
    end
  endtask

  // Whole packets in round-robin order from the model pointer; a packet
  // longer than MAXL is cut, and its tail queues up as a fresh packet.
  task automatic model_schedule();
    while (1) begin
      int p;
      int n;
      bit done;
      logic [16:0] f;
      bit frc;
      p = -1;
      for (int k = PORTS - 1; k >= 0; k--) begin
        if (m_q[(m_rr + k) % PORTS].size() > 0) p = (m_rr + k) % PORTS;
      end
      if (p < 0) break;
      n = 0;
      done = 0;
      while (!done) begin
        f = m_q[p].pop_front();
        n++;
        frc = (n == MAXL) && !f[16];
        exp_q.push_back({frc, 2'(p), (f[16] | frc), f[15:0]});
        exp_pushed++;
        if (frc) ovf_exp++;
        done = f[16] | frc;
      end
      m_rr = (p + 1) % PORTS;
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    logic [PORTS-1:0] fired;
    logic [16:0]      f;
    dii_flit          t;
    bus.in_flit   = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < PORTS; i++) fired[i] = bus.in_flit[i].valid && bus.in_ready[i];
      @(posedge clk);
      #1;
      if (rst) fired = '0;
      for (int i = 0; i < PORTS; i++) begin
        if (fired[i] && drv_q[i].size() > 0) begin
          f = drv_q[i].pop_front();
          if (f[16] || mid_cnt[i] + 1 == MAXL) mid_cnt[i] = 0;
          else mid_cnt[i]++;
        end
        t = '0;
        if (drv_q[i].size() > 0) begin
          t.data  = drv_q[i][0][15:0];
          t.last  = drv_q[i][0][16];
          t.valid = !(gap_en && mid_cnt[i] != 0 && $urandom_range(0, 3) == 0);
        end
        bus.in_flit[i] = t;
      end
      bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    dii_flit      prev_flit;
    bit           prev_stall;
    prev_stall = 0;
    prev_flit  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      check("in_ready_onehot", 32'($onehot0(bus.in_ready)), 1);
      for (int i = 0; i < PORTS; i++) if (bus.in_flit[i].valid && bus.in_ready[i]) in_fire_cnt++;
      if (overflow_err) ovf_seen++;
      if (prev_stall) check("out_stable", 32'(bus.out_flit), 32'(prev_flit));
      prev_stall = bus.out_flit.valid && !bus.out_ready;
      prev_flit  = bus.out_flit;
      if (bus.out_flit.valid && bus.out_ready) begin
        out_fire_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got flit %0h, expected no flit", bus.out_flit);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {bus.out_flit.last, bus.out_flit.data}, 32'(e[16:0]));
          if (strict) begin
            check("active_port", 32'(active_port), 32'(e[18:17]));
            check("ovf_pulse", 32'(overflow_err), 32'(e[19]));
            if (have_prev) check("pkt_spacing", cyc - pop_prev_cyc, pop_prev_last ? 2 : 1);
          end
          have_prev     = 1;
          pop_prev_cyc  = cyc;
          pop_prev_last = e[16];
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  function automatic bit pending();
    bit b;
    b = (exp_q.size() > 0) || bus.out_flit.valid;
    for (int i = 0; i < PORTS; i++) if (drv_q[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic clear_bench();
    for (int i = 0; i < PORTS; i++) begin
      drv_q[i].delete();
      m_q[i].delete();
      mid_cnt[i] = 0;
    end
    exp_q.delete();
    m_rr = 0;
    in_fire_cnt = 0; out_fire_cnt = 0; ovf_seen = 0; ovf_exp = 0; exp_pushed = 0;
    have_prev = 0;
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    clear_bench();
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_flit.valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_active_port", 32'(active_port), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_overflow", 32'(overflow_err), 0);
  endtask

  task automatic start_phase(input bit s, input bit g, input bit rr_rand);
    sync();
    strict    = s;
    gap_en    = g;
    rdy_rand  = rr_rand;
    rdy_force = 1;
    have_prev = 0;
  endtask

  task automatic end_phase(input int budget, input string name);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (pending()) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: %0d flits still expected after %0d cycles", name, exp_q.size(), budget);
      do_reset();
      return;
    end
    sync();
    check({"flit_count_", name}, out_fire_cnt, exp_pushed);
    check({"ovf_count_", name}, ovf_seen, ovf_exp);
    check({"idle_", name}, 32'(dbg_state), 32'(ST_IDLE));
    in_fire_cnt = 0; out_fire_cnt = 0; ovf_seen = 0; ovf_exp = 0; exp_pushed = 0;
  endtask

  task automatic wait_count(input bit use_out, input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((use_out ? out_fire_cnt : in_fire_cnt) < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if ((use_out ? out_fire_cnt : in_fire_cnt) < target) begin
      errors++;
      $display("FAIL wait_%s: count %0d required %0d", name, use_out ? out_fire_cnt : in_fire_cnt, target);
    end
    sync();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int np;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("init_out_valid", 32'(bus.out_flit.valid), 0);
    check("init_in_ready", 32'(bus.in_ready), 0);
    check("init_active_port", 32'(active_port), 0);
    check("init_state", 32'(dbg_state), 32'(ST_IDLE));

    // all ports offering 2-flit packets back to back
    start_phase(1, 0, 0);
    for (int r = 0; r < 2; r++) for (int p = 0; p < PORTS; p++) load_pkt(p, 2, 0, 0);
    model_schedule();
    end_phase(200, "rr_order");

    // port0 shows up while port1's packet is in flight
    start_phase(1, 0, 0);
    load_pkt(1, 4, 0, 0);
    model_schedule();
    wait_count(0, 2, 50, "port1_flit2");
    load_pkt(0, 2, 0, 0);
    model_schedule();
    end_phase(200, "atomic");

    // alternating single-flit packets
    start_phase(1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      load_pkt(0, 1, 1, 16'h1234);
      load_pkt(1, 1, 1, 16'hABCD);
    end
    model_schedule();
    end_phase(200, "single");

    // length-limit abort
    start_phase(1, 0, 0);
    load_pkt(2, 6, 0, 0);
    model_schedule();
    end_phase(200, "overflow");

    // ring back-pressure for 10 cycles mid-packet
    start_phase(0, 0, 0);
    load_pkt(0, 4, 0, 0);
    load_pkt(1, 4, 0, 0);
    model_schedule();
    wait_count(1, 1, 50, "bp_first");
    rdy_force = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_held", in_fire_cnt - out_fire_cnt, 2);
    check("bp_in_ready", 32'(bus.in_ready), 0);
    check("bp_out_valid", 32'(bus.out_flit.valid), 1);
    sync();
    rdy_force = 1;
    end_phase(200, "backpressure");

    // reset in the middle of a packet, then a clean restart from port0
    start_phase(0, 0, 0);
    load_pkt(1, 4, 0, 0);
    load_pkt(2, 4, 0, 0);
    model_schedule();
    wait_count(1, 2, 50, "pre_reset");
    do_reset();
    start_phase(1, 0, 0);
    for (int p = 0; p < PORTS; p++) load_pkt(p, 2, 0, 0);
    model_schedule();
    end_phase(200, "post_reset");

    // randomized traffic, valid gaps and ring stalls
    for (int r = 0; r < 8; r++) begin
      start_phase(0, 1, 1);
      np = 0;
      for (int p = 0; p < PORTS; p++) begin
        int k;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
          load_pkt(p, $urandom_range(1, 6), 0, 0);
          np++;
        end
      end
      if (np == 0) load_pkt($urandom_range(0, PORTS - 1), $urandom_range(1, 6), 0, 0);
      model_schedule();
      end_phase(2000, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
